// File: rtl/vx_dcache_responder_if.sv
// Request/response bundle between a multi-lane requester and the dcache responder.
// The master drives requests and accepts responses; the slave is the responder.
interface vx_dcache_responder_if #(
  parameter int NUM_THREADS = 4,
  parameter int TAG_WIDTH   = 8
);
  logic [NUM_THREADS-1:0]                req_valid;
  logic [NUM_THREADS-1:0]                req_rw;
  logic [NUM_THREADS-1:0][29:0]          req_addr;
  logic [NUM_THREADS-1:0][3:0]           req_byteen;
  logic [NUM_THREADS-1:0][31:0]          req_data;
  logic [NUM_THREADS-1:0][TAG_WIDTH-1:0] req_tag;
  logic [NUM_THREADS-1:0]                req_ready;

  logic                                  rsp_valid;
  logic [NUM_THREADS-1:0]                rsp_tmask;
  logic [NUM_THREADS-1:0][31:0]          rsp_data;
  logic [TAG_WIDTH-1:0]                  rsp_tag;
  logic                                  rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_dcache_responder.sv
// Multi-lane scratchpad responder: accepts a lane batch, serves one lane per cycle
// (lowest first) against a word array, and returns one load response per batch.
module vx_dcache_responder #(
  parameter int NUM_THREADS = 4,
  parameter int WORDS       = 1024,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_dcache_responder_if.slave  bus
);

  localparam int IDX = $clog2(WORDS);
  localparam int LW  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESP
  } state_e;

  state_e                                state_q, state_d;
  logic [NUM_THREADS-1:0]                pending_q, pending_d;
  logic [NUM_THREADS-1:0]                mask_q, mask_d;
  logic                                  op_q, op_d;
  logic [TAG_WIDTH-1:0]                  tag_q, tag_d;
  logic [NUM_THREADS-1:0][IDX-1:0]       addr_q, addr_d;
  logic [NUM_THREADS-1:0][3:0]           byteen_q, byteen_d;
  logic [NUM_THREADS-1:0][31:0]          data_q, data_d;
  logic [NUM_THREADS-1:0][31:0]          rsp_data_q, rsp_data_d;

  logic [31:0]                           mem [WORDS];
  logic                                  mem_we;
  logic [IDX-1:0]                        mem_idx;
  logic [31:0]                           mem_wdata;
  logic [3:0]                            mem_be;
  logic [LW-1:0]                         serve_lane;

  // Address bits above the scratchpad index alias onto the same words.
  wire unused_addr = ^bus.req_addr;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    mask_d     = mask_q;
    op_d       = op_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    byteen_d   = byteen_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    mem_we     = 1'b0;
    serve_lane = '0;

    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (pending_q[i]) serve_lane = LW'(i);
    end

    mem_idx   = addr_q[serve_lane];
    mem_wdata = data_q[serve_lane];
    mem_be    = byteen_q[serve_lane];

    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          pending_d  = bus.req_valid;
          mask_d     = bus.req_valid;
          rsp_data_d = '0;
          byteen_d   = bus.req_byteen;
          data_d     = bus.req_data;
          for (int i = 0; i < NUM_THREADS; i++) begin
            addr_d[i] = bus.req_addr[i][IDX-1:0];
          end
          // Whole batch takes its op and tag from the lowest valid lane.
          for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
              op_d  = bus.req_rw[i];
              tag_d = bus.req_tag[i];
            end
          end
          state_d = SERVE;
        end
      end
      SERVE: begin
        pending_d[serve_lane] = 1'b0;
        if (op_q) begin
          mem_we = 1'b1;
        end else begin
          rsp_data_d[serve_lane] = mem[addr_q[serve_lane]];
        end
        if (pending_d == '0) begin
          state_d = op_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      mask_q     <= '0;
      op_q       <= 1'b0;
      tag_q      <= '0;
      addr_q     <= '0;
      byteen_q   <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      byteen_q   <= byteen_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // The scratchpad is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  assign bus.req_ready = {NUM_THREADS{state_q == IDLE}};
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_tmask = mask_q;
  assign bus.rsp_tag   = tag_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
